// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one AND/XOR/NAND/ADD alu among requesters.
// The result is held in a one-entry output register tagged with the owner id.
module alu_rr_arbiter #(
    parameter int width_p    = 8,
    parameter int num_req_p  = 4,
    parameter int id_width_p = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [num_req_p-1:0]         v_i,
    input  logic [num_req_p*2-1:0]       sel_i,
    input  logic [num_req_p*width_p-1:0] a_i,
    input  logic [num_req_p*width_p-1:0] b_i,
    output logic [num_req_p-1:0]         yumi_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    output logic [id_width_p-1:0]        id_o,
    input  logic                         ready_i
);

    logic [id_width_p-1:0] ptr_r;
    logic [id_width_p-1:0] gnt_id;
    logic [id_width_p-1:0] cand;
    logic                  found;
    logic                  slot_free;
    int                    pos;

    logic [1:0]            op_sel;
    logic [width_p-1:0]    op_a;
    logic [width_p-1:0]    op_b;
    logic [width_p-1:0]    alu_res;

    // A result can be accepted when the slot is empty or being drained now.
    assign slot_free = ~v_o | ready_i;

    // Search ptr_r, ptr_r+1, ... ; walking downward lets the nearest win.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        cand   = '0;
        pos    = 0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            pos = int'(ptr_r) + k;
            if (pos >= num_req_p) begin
                pos = pos - num_req_p;
            end
            cand = id_width_p'(pos);
            if (v_i[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
        if (!(slot_free && reset_n_i)) begin
            found = 1'b0;
        end
    end

    assign yumi_o = found ? (num_req_p'(1) << gnt_id) : '0;

    assign op_sel = sel_i[gnt_id*2 +: 2];
    assign op_a   = a_i[gnt_id*width_p +: width_p];
    assign op_b   = b_i[gnt_id*width_p +: width_p];

    // Single shared alu; ADD drops the carry-out.
    always_comb begin
        alu_res = '0;
        unique case (op_sel)
            2'b00: alu_res = op_a & op_b;
            2'b01: alu_res = op_a ^ op_b;
            2'b10: alu_res = ~(op_a & op_b);
            2'b11: alu_res = op_a + op_b;
        endcase
    end

    // Capture the granted result, advance the pointer, drain on ready.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o    <= 1'b0;
            data_o <= '0;
            id_o   <= '0;
            ptr_r  <= '0;
        end else if (found) begin
            v_o    <= 1'b1;
            data_o <= alu_res;
            id_o   <= gnt_id;
            if (gnt_id == id_width_p'(num_req_p - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= gnt_id + 1'b1;
            end
        end else if (ready_i) begin
            v_o <= 1'b0;
        end
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one alu datapath (width_p-bit AND/XOR/NAND/ADD) among num_req_p requesters.
- Each requester presents an operation with a valid/yumi handshake.
- Round-robin arbitration picks at most one request per cycle and applies it to the alu.
- The result is captured in a one-entry output register and returned with the requester id over a valid/ready handshake.
- Sits between multiple issue sources (e.g. per-lane sequencers) and the single shared alu.

Parameters:
- width_p, 8, operand/result width; must be ≥ 1.
- num_req_p, 4, number of requesters; must be ≥ 1.
- id_width_p, `BSG_SAFE_CLOG2(num_req_p), width of the returned requester id.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  num_req_p  per-requester request valid.
- sel_i  in  num_req_p*2  per-requester op select: 00 AND, 01 XOR, 10 NAND, 11 ADD.
- a_i  in  num_req_p*width_p  per-requester operand A (requester r at bits [r*width_p +: width_p]).
- b_i  in  num_req_p*width_p  per-requester operand B (same packing).
- yumi_o  in/out: out  num_req_p  one-hot grant; request consumed this cycle.
- v_o  out  1  result valid.
- data_o  out  width_p  result.
- id_o  out  id_width_p  index of the requester that owns data_o.
- ready_i  in  1  consumer accepts result when v_o & ready_i.

Behaviour:
- Reset: clock is one; reset is asynchronous and active-low (reset_n_i). While reset_n_i=0:
  - v_o=0, data_o=0, id_o=0.
  - Round-robin pointer ptr_r=0.
  - yumi_o=0 regardless of v_i.
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Reset mid-operation discards any held result; no result is replayed after reset release.
- Slot availability: slot_free = ~v_o | ready_i. A dequeue and a new grant in the same cycle are allowed; throughput is 1 result/cycle while ready_i=1.
- Arbitration (combinational):
  - If slot_free, grant the first requester with v_i=1, searching ptr_r, ptr_r+1, … mod num_req_p.
  - yumi_o is one-hot or zero.
  - yumi_o depends on v_i, ptr_r, v_o and ready_i only, never on sel_i/a_i/b_i.
- Pointer update: on a grant to requester g, ptr_r <= (g+1) mod num_req_p. With no grant, ptr_r holds. With num_req_p=1, ptr_r stays 0.
- Datapath:
  - The granted requester's sel/a/b are muxed into a single alu instance.
  - The alu output is registered on the grant edge: data_o <= alu result, id_o <= g, v_o <= 1.
  - Latency: grant cycle N → v_o=1 at cycle N+1.
  - ADD is modulo 2^width_p; carry-out is discarded. NAND is the bitwise ~(a&b).
- Hold: if v_o=1 and ready_i=0, then data_o, id_o and v_o are stable and yumi_o=0.
- Drain: if v_o & ready_i and no grant in that cycle, then v_o <= 0 next cycle; data_o and id_o hold their last value.
- Requester contract:
  - v_i may drop only after yumi_o.
  - Operands must be stable while v_i=1 and not yet granted.
  - A deasserted v_i is never granted.
- ready_i while v_o=0 has no effect.
- Fairness: with all requesters continuously valid and ready_i=1, each requester is granted exactly once in every num_req_p consecutive grants.

Test Plan (width_p=8, num_req_p=4):
- Reset: drive reset_n_i=0 asynchronously mid-cycle with v_o=1 → v_o=0, yumi_o=0 immediately. Release, then v_i=4'b0001 → grant to requester 0; ptr_r then advances to 1.
- Op coverage: requester 2 with a=8'hF0, b=8'h3C; for sel=00/01/10/11 expect data_o=8'h30/8'hCC/8'hCF/8'h2C, id_o=2, each 1 cycle after yumi_o[2].
- Round robin: v_i=4'b1111 held, ready_i=1, 8 cycles → grant order 0,1,2,3,0,1,2,3; v_o=1 continuously from cycle 2; id_o follows the same sequence.
- Backpressure: v_o=1, ready_i=0 for 5 cycles with v_i=4'b0110 → yumi_o=0 and data_o/id_o stable. When ready_i=1 rises, a grant occurs in the same cycle and the new result appears next cycle with no bubble.
- Skip/hold pointer: ptr_r=1, v_i=4'b0001 → grant 0, ptr_r=1. Then v_i=0 for 3 cycles → no grant, ptr_r stays 1, v_o drops after one drain.
- ADD wrap: a=8'hFF, b=8'h02, sel=11 → data_o=8'h01; no other output changes.
